sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter.sv | 140 ++++++++++++++
 tb/tb_sqrt_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Four-requester arbiter sharing one fixed-latency square-root engine.
// Round-robin by default; define SQRT_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
module sqrt_arbiter #(
   parameter int unsigned ENGINE_LAT = 20
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [3:0]  req,
   input  logic [31:0] a_bus,
   output logic [3:0]  done,
   output logic [3:0]  root,
   output logic        busy,
   output logic        eng_start,
   output logic [7:0]  eng_a,
   input  logic [3:0]  eng_sqrt
);

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned OPND_W = 8;
   localparam int unsigned RES_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ENGINE_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_owner;
   logic [N_REQ-1:0]    r_done;
   logic [RES_W-1:0]    r_root;
   logic                r_busy;
   logic                r_eng_start;
   logic [OPND_W-1:0]   r_eng_a;
   logic [IDX_W-1:0]    w_base;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    w_sel;
   logic                w_found;
   logic [OPND_W-1:0]   w_opnd;

`ifdef SQRT_ARB_FIXED_PRIO_EN
   assign w_base = '0;
`else
   logic [IDX_W-1:0]    r_ptr;

   // Pointer moves past the owner once its transaction completes.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_ptr <= '0;
      end else if (r_state == S_DONE) begin
         r_ptr <= r_owner + IDX_W'(1);
      end
   end

   assign w_base = r_ptr;
`endif

   // First active request scanning upward from w_base, wrapping 3->0.
   always_comb begin
      w_sel   = w_base;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         w_idx = w_base + IDX_W'(k);
         if (!w_found && req[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_opnd = a_bus[{w_sel, 3'b000} +: OPND_W];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (|req) w_next = S_LOAD;
         S_LOAD:  w_next = S_WAIT;
         S_WAIT:  if (r_cnt == LAT_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // WAIT occupies exactly ENGINE_LAT cycles: count 0..ENGINE_LAT-1.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // Outputs are registered against the next state so they line up with it.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_owner     <= '0;
         r_done      <= '0;
         r_root      <= '0;
         r_busy      <= 1'b0;
         r_eng_start <= 1'b0;
         r_eng_a     <= '0;
      end else begin
         r_busy      <= (w_next != S_IDLE);
         r_eng_start <= (w_next == S_LOAD);
         r_done      <= '0;
         if (r_state == S_IDLE && (|req)) begin
            r_owner <= w_sel;
            r_eng_a <= w_opnd;
         end
         if (w_next == S_DONE) begin
            r_done <= N_REQ'(1) << r_owner;
            r_root <= eng_sqrt;
         end
      end
   end

   assign done      = r_done;
   assign root      = r_root;
   assign busy      = r_busy;
   assign eng_start = r_eng_start;
   assign eng_a     = r_eng_a;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural engine, transaction-timeline reference model,
// vector table, hand-written corner sequences and randomized request traffic.
module tb_sqrt_arbiter;

   localparam int unsigned LAT = 20;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  req;
   logic [31:0] a_bus;
   logic [3:0]  done;
   logic [3:0]  root;
   logic        busy;
   logic        eng_start;
   logic [7:0]  eng_a;
   logic [3:0]  eng_sqrt = 4'd0;

   int n_cmp = 0;
   int n_bad = 0;

   sqrt_arbiter #(.ENGINE_LAT(LAT)) dut (
      .clk(clk), .clr(clr), .req(req), .a_bus(a_bus), .done(done), .root(root),
      .busy(busy), .eng_start(eng_start), .eng_a(eng_a), .eng_sqrt(eng_sqrt)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] isqrt(input logic [7:0] a);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(a)) r++;
      return 4'(r);
   endfunction

   // Engine: result valid LAT cycles after the start pulse, junk before that.
   int         eng_cnt = 0;
   logic [7:0] eng_op  = 8'd0;
   always @(posedge clk) begin
      if (eng_start) begin
         eng_op   <= eng_a;
         eng_cnt  <= LAT - 1;
         eng_sqrt <= ~isqrt(eng_a);
      end else if (eng_cnt > 1) begin
         eng_cnt <= eng_cnt - 1;
      end else if (eng_cnt == 1) begin
         eng_cnt  <= 0;
         eng_sqrt <= isqrt(eng_op);
      end
   end

   // Reference model: m_t = cycles since a request was accepted (0 = idle).
   int         m_t = 0;
   logic [1:0] m_ptr = 2'd0;
   logic [1:0] m_own = 2'd0;
   logic [7:0] m_eng_a = 8'd0;
   logic [3:0] m_root = 4'd0;

   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] ptr);
      int base;
`ifdef SQRT_ARB_FIXED_PRIO_EN
      base = 0;
`else
      base = int'(ptr);
`endif
      for (int k = 0; k < 4; k++) begin
         if (r[(base + k) % 4]) return 2'((base + k) % 4);
      end
      return 2'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!clr) begin
         m_t = 0; m_ptr = 2'd0; m_own = 2'd0; m_eng_a = 8'd0; m_root = 4'd0;
      end else if (m_t == 0) begin
         if (req != 4'd0) begin
            m_own   = pick(req, m_ptr);
            m_eng_a = a_bus[m_own*8 +: 8];
            m_t     = 1;
         end
      end else if (m_t == int'(LAT) + 2) begin
         m_ptr = m_own + 2'd1;
         m_t   = 0;
      end else begin
         m_t++;
      end
      if (m_t == int'(LAT) + 2) m_root = isqrt(m_eng_a);
      @(negedge clk);
      chk("busy", 32'(busy), 32'(m_t != 0));
      chk("eng_start", 32'(eng_start), 32'(m_t == 1));
      chk("done", 32'(done), (m_t == int'(LAT) + 2) ? (32'd1 << m_own) : 32'd0);
      chk("root", 32'(root), 32'(m_root));
      chk("eng_a", 32'(eng_a), 32'(m_eng_a));
   endtask

   task automatic wait_done(input int budget, output int n, output logic [3:0] d);
      n = 0;
      d = 4'd0;
      while (n < budget && d == 4'd0) begin
         tick();
         n++;
         d = done;
      end
      if (d == 4'd0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      clr = 1'b0;
      req = 4'd0;
      tick();
      tick();
      clr = 1'b1;
   endtask

   typedef struct {
      logic [3:0] req;
      logic [7:0] a;
      logic [3:0] exp_done;
      logic [3:0] exp_root;
   } vec_t;

   vec_t vecs[8];
   logic [3:0] exp_ord[5];
   logic [3:0] exp_rt[5];

   initial begin
      int n;
      logic [3:0] d;
      int p;

      vecs[0] = '{4'b0100, 8'd144, 4'b0100, 4'd12};
      vecs[1] = '{4'b0001, 8'd0,   4'b0001, 4'd0};
      vecs[2] = '{4'b1000, 8'd255, 4'b1000, 4'd15};
      vecs[3] = '{4'b0010, 8'd1,   4'b0010, 4'd1};
      vecs[4] = '{4'b0001, 8'd3,   4'b0001, 4'd1};
      vecs[5] = '{4'b0100, 8'd224, 4'b0100, 4'd14};
      vecs[6] = '{4'b1000, 8'd15,  4'b1000, 4'd3};
      vecs[7] = '{4'b0010, 8'd16,  4'b0010, 4'd4};

      clr   = 1'b0;
      req   = 4'd0;
      a_bus = 32'd0;
      #2;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(eng_start), 32'd0);
      chk("rst_root", 32'(root), 32'd0);
      chk("rst_eng_a", 32'(eng_a), 32'd0);
      tick();
      tick();
      clr = 1'b1;

      // Single requests from the vector table.
      foreach (vecs[v]) begin
         p = 0;
         for (int i = 0; i < 4; i++) if (vecs[v].req[i]) p = i;
         a_bus = $urandom;
         a_bus[p*8 +: 8] = vecs[v].a;
         req = vecs[v].req;
         tick();
         chk("vec_start", 32'(eng_start), 32'd1);
         chk("vec_eng_a", 32'(eng_a), 32'(vecs[v].a));
         wait_done(LAT + 5, n, d);
         chk("vec_latency", 32'(n + 1), 32'(LAT + 2));
         chk("vec_done", 32'(d), 32'(vecs[v].exp_done));
         chk("vec_root", 32'(root), 32'(vecs[v].exp_root));
         req = 4'd0;
         tick();
         chk("vec_single_pulse", 32'(done), 32'd0);
      end

      // All four held: rotation (or starvation under fixed priority).
      do_reset();
      a_bus = {8'd25, 8'd16, 8'd9, 8'd4};
`ifdef SQRT_ARB_FIXED_PRIO_EN
      for (int j = 0; j < 5; j++) begin exp_ord[j] = 4'b0001; exp_rt[j] = 4'd2; end
`else
      exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_rt  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2};
`endif
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_done(LAT + 10, n, d);
         chk("rr_order", 32'(d), 32'(exp_ord[j]));
         chk("rr_root", 32'(root), 32'(exp_rt[j]));
      end
      req = 4'd0;
      tick();

      // Reset ten cycles into WAIT, then pointer must restart at 0.
      do_reset();
      a_bus = 32'd0;
      a_bus[15:8] = 8'd49;
      req = 4'b0010;
      wait_done(LAT + 5, n, d);
      chk("pre_rst_done", 32'(d), 32'b0010);
      req = 4'd0;
      tick();
      a_bus[23:16] = 8'd100;
      req = 4'b0100;
      tick();
      chk("midwait_start", 32'(eng_start), 32'd1);
      for (int j = 0; j < 10; j++) tick();
      clr = 1'b0;
      #1;
      chk("midwait_busy", 32'(busy), 32'd0);
      chk("midwait_done", 32'(done), 32'd0);
      chk("midwait_eng_a", 32'(eng_a), 32'd0);
      req = 4'd0;
      tick();
      tick();
      clr = 1'b1;
      a_bus = {8'd81, 8'd0, 8'd0, 8'd64};
      req = 4'b1001;
      tick();
      chk("post_rst_start", 32'(eng_start), 32'd1);
      chk("post_rst_eng_a", 32'(eng_a), 32'd64);
      wait_done(LAT + 5, n, d);
      chk("post_rst_latency", 32'(n + 1), 32'(LAT + 2));
      chk("post_rst_done", 32'(d), 32'b0001);
      chk("post_rst_root", 32'(root), 32'd8);
      req = 4'd0;
      for (int j = 0; j < int'(LAT) + 5; j++) tick();

      // Requester 1 withdraws during WAIT while requester 2 arrives.
      do_reset();
      a_bus = {8'd0, 8'd121, 8'd36, 8'd0};
      req = 4'b0010;
      tick();
      chk("aband_start", 32'(eng_start), 32'd1);
      for (int j = 0; j < 5; j++) tick();
      req = 4'b0100;
      wait_done(LAT + 5, n, d);
      chk("aband_latency", 32'(n), 32'(LAT - 4));
      chk("aband_done", 32'(d), 32'b0010);
      chk("aband_root", 32'(root), 32'd6);
      wait_done(LAT + 10, n, d);
      chk("late_latency", 32'(n), 32'(LAT + 3));
      chk("late_done", 32'(d), 32'b0100);
      chk("late_root", 32'(root), 32'd11);
      req = 4'd0;
      tick();

      // Random traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               if (done[i]) begin
                  if ($urandom_range(1) == 0) req[i] = 1'b0;
               end else if ($urandom_range(63) == 0) begin
                  req[i] = 1'b0;
               end
            end else if ($urandom_range(7) == 0) begin
               req[i] = 1'b1;
               a_bus[i*8 +: 8] = 8'($urandom);
            end
         end
         if ($urandom_range(499) == 0) begin
            clr = 1'b0;
            tick();
            clr = 1'b1;
         end
         tick();
      end
      req = 4'd0;
      for (int j = 0; j < int'(LAT) + 5; j++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
